multicycle_ctrl_v2: RTL
=======================

# multicycle_ctrl_v2

Parametrised successor to the multicycle MIPS control unit. A Moore FSM sequences fetch, decode, execute, memory and write-back for one instruction at a time, and drives the shared datapath muxes, register file, IR and PC write enables. Compared with the previous unit it adds:
- a memory ready handshake with an optional timeout watchdog;
- slti/ori support with a wider ALU-op field;
- opcode latching, illegal-opcode detection and an instruction-done strobe.

## Interface
- MEM_WAIT, default 1: 1 = memory states wait for `mem_ready`; 0 = `mem_ready` ignored and treated as 1.
- MAX_WAIT, default 0: cycles a memory state may wait before timing out; 0 disables the watchdog. Legal range 0..255.
- clk  in  1  clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high reset.
- opcode  in  6  instruction opcode from the IR; sampled in DECODE only.
- mem_ready  in  1  memory access completes in the current cycle.
- alusrcA  out  1  0 = PC, 1 = register A.
- alusrcB  out  2  00 = register B, 01 = constant 4, 10 = extended imm, 11 = sign-extended imm<<2.
- ext_zero  out  1  1 = zero-extend imm (andi/ori), 0 = sign-extend.
- aluop  out  3  000 add, 001 sub, 010 use funct, 011 and, 100 or, 101 slt.
- memread, memwrite, IorD, IR_write, regwrite  out  1 each  standard meanings; IorD 1 = ALUOut address.
- regdst  out  2  00 = rt, 01 = rd, 10 = $31.
- memtoreg  out  2  00 = ALUOut, 01 = MDR, 10 = PC.
- pcsrc  out  2  00 = ALU result, 01 = branch/jump target, 10 = register A.
- pc_write, pc_write_condition_beq, pc_write_condition_bne  out  1 each  PC write enables; the datapath combines the conditional enables with `zero`.
- instr_done  out  1  one-cycle pulse on the last cycle of each instruction.
- illegal_op  out  1  one-cycle pulse when an unsupported opcode is decoded.
- mem_timeout  out  1  one-cycle pulse when the watchdog expires.
- state  out  4  current state, for debug.

## Operation
- State encoding (4 bits): FETCH=0, DECODE=1, EXEC_R=2, EXEC_I=3, ALU_WB=4, MEM_ADDR=5, MEM_RD=6, MEM_WB=7, MEM_WR=8, BRANCH=9, JUMP=10, JAL=11, JR=12. Codes 13–15 are unreachable and transition to FETCH.
- All outputs are combinational decodes of `state` and the latched opcode `op_q`. Every output not listed for a state is 0.
- FETCH:
  - Outputs: memread=1, IorD=0, alusrcA=0, alusrcB=01, aluop=000, pcsrc=00.
  - IR_write=1 and pc_write=1 only in the cycle where `mem_ready` (effective) is 1.
  - Holds until `mem_ready`, then goes to DECODE.
- DECODE:
  - Outputs: alusrcA=0, alusrcB=11, aluop=000 (branch target into ALUOut).
  - Latches `op_q <= opcode`.
  - Next state by opcode: 000000→EXEC_R; 001000/001010/001100/001101→EXEC_I; 100011/101011→MEM_ADDR; 000100/000101→BRANCH; 000010→JUMP; 000011→JAL; 000001→JR.
  - Any other opcode: illegal_op=1, instr_done=1, next state FETCH.
- EXEC_R: alusrcA=1, alusrcB=00, aluop=010; next ALU_WB.
- EXEC_I:
  - alusrcA=1, alusrcB=10.
  - aluop: addi 000, slti 101, andi 011, ori 100.
  - ext_zero=1 for andi/ori.
  - Next ALU_WB.
- ALU_WB: regwrite=1, memtoreg=00, regdst=01 if op_q=R-type else 00; instr_done=1; next FETCH.
- MEM_ADDR: alusrcA=1, alusrcB=10, aluop=000; next MEM_RD (lw) or MEM_WR (sw).
- MEM_RD: memread=1, IorD=1; holds until `mem_ready`, then MEM_WB.
- MEM_WB: regwrite=1, regdst=00, memtoreg=01, instr_done=1; next FETCH.
- MEM_WR: memwrite=1, IorD=1; holds until `mem_ready`, then instr_done=1 and next FETCH.
- BRANCH:
  - alusrcA=1, alusrcB=00, aluop=001, pcsrc=01.
  - pc_write_condition_beq=1 (beq) or pc_write_condition_bne=1 (bne).
  - instr_done=1; next FETCH.
- JUMP: pc_write=1, pcsrc=01, instr_done=1; next FETCH.
- JAL: pc_write=1, pcsrc=01, regwrite=1, regdst=10, memtoreg=10, instr_done=1; next FETCH.
- JR: pc_write=1, pcsrc=10, instr_done=1; next FETCH.
- Watchdog (MAX_WAIT>0):
  - An 8-bit counter clears on entry to any memory state (FETCH, MEM_RD, MEM_WR) and increments each cycle the state waits with `mem_ready`=0.
  - When the counter equals MAX_WAIT while `mem_ready`=0: mem_timeout=1 and next state is FETCH. No IR_write, pc_write or register write occurs.
  - `mem_ready`=1 in the same cycle the counter reaches MAX_WAIT wins: the access completes normally and no timeout is flagged.
- MEM_WAIT=0: memory states always complete in one cycle; the watchdog is inert.

## Timing
- Reset:
  - While `reset`=1, every output except `state` is forced to 0.
  - On the edge: state←FETCH, op_q←0, watchdog counter←0.
  - First fetch is asserted in the cycle after `reset` falls.
  - Reset mid-instruction aborts it; no further write enables are asserted.
- Cycles per instruction with `mem_ready` held at 1:
  - R, addi, slti, andi, ori: 4.
  - lw: 5.
  - sw: 4.
  - beq, bne, j, jal, jr: 3.
  - Each wait cycle in FETCH, MEM_RD or MEM_WR adds 1.
- `opcode` changes after DECODE do not affect the instruction in flight.
- instr_done, illegal_op and mem_timeout are each exactly one cycle wide.

## Test plan
- Reset, then addi with `mem_ready`=1 → state sequence 0,1,3,4,0; regwrite=1, regdst=00 only in cycle 4; instr_done pulses once.
- lw with `mem_ready` low for 3 cycles in MEM_RD → memread=1, IorD=1 held 4 cycles; MEM_WB regwrite=1, memtoreg=01; total 8 cycles.
- MAX_WAIT=4, FETCH with `mem_ready` stuck at 0 → mem_timeout pulses on the 5th FETCH cycle; IR_write and pc_write never 1; next state FETCH.
- Opcode 111111 → illegal_op=1 and instr_done=1 in DECODE; no regwrite, memwrite or pc_write; back in FETCH after 2 cycles.
- beq then bne → BRANCH with aluop=001, pcsrc=01, and only the matching conditional enable set; jal → regwrite=1, regdst=10, memtoreg=10, pc_write=1.
- `reset` asserted during MEM_WR → memwrite=0 in that cycle; FETCH on the next edge; ori afterwards drives ext_zero=1, aluop=100.

Source files
------------

// File: rtl/multicycle_ctrl_v2.sv
// Multicycle MIPS control unit: Moore FSM sequencing fetch/decode/execute/memory/write-back,
// with a memory ready handshake, optional wait watchdog and per-instruction status strobes.
module multicycle_ctrl_v2 #(
  parameter bit          MEM_WAIT = 1'b1,
  parameter int unsigned MAX_WAIT = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       alusrcA,
  output logic [1:0] alusrcB,
  output logic       ext_zero,
  output logic [2:0] aluop,
  output logic       memread,
  output logic       memwrite,
  output logic       IorD,
  output logic       IR_write,
  output logic       regwrite,
  output logic [1:0] regdst,
  output logic [1:0] memtoreg,
  output logic [1:0] pcsrc,
  output logic       pc_write,
  output logic       pc_write_condition_beq,
  output logic       pc_write_condition_bne,
  output logic       instr_done,
  output logic       illegal_op,
  output logic       mem_timeout,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    StFetch   = 4'd0,
    StDecode  = 4'd1,
    StExecR   = 4'd2,
    StExecI   = 4'd3,
    StAluWb   = 4'd4,
    StMemAddr = 4'd5,
    StMemRd   = 4'd6,
    StMemWb   = 4'd7,
    StMemWr   = 4'd8,
    StBranch  = 4'd9,
    StJump    = 4'd10,
    StJal     = 4'd11,
    StJr      = 4'd12
  } state_e;

  localparam logic [5:0] OpRtype = 6'b000000;
  localparam logic [5:0] OpAddi  = 6'b001000;
  localparam logic [5:0] OpSlti  = 6'b001010;
  localparam logic [5:0] OpAndi  = 6'b001100;
  localparam logic [5:0] OpOri   = 6'b001101;
  localparam logic [5:0] OpLw    = 6'b100011;
  localparam logic [5:0] OpSw    = 6'b101011;
  localparam logic [5:0] OpBeq   = 6'b000100;
  localparam logic [5:0] OpBne   = 6'b000101;
  localparam logic [5:0] OpJ     = 6'b000010;
  localparam logic [5:0] OpJal   = 6'b000011;
  localparam logic [5:0] OpJr    = 6'b000001;

  localparam logic [7:0] MaxWait = MAX_WAIT[7:0];

  state_e     state_q, state_d;
  logic [5:0] op_q, op_d;
  logic [7:0] wait_q, wait_d;
  logic       rdy;
  logic       in_mem_state;
  logic       timeout;

  assign rdy          = MEM_WAIT ? mem_ready : 1'b1;
  assign in_mem_state = (state_q == StFetch) || (state_q == StMemRd) || (state_q == StMemWr);
  assign timeout      = (MAX_WAIT != 0) && in_mem_state && !rdy && (wait_q == MaxWait);
  assign state        = state_q;

  // Counter only survives while a memory state keeps waiting; any move or timeout clears it.
  always_comb begin
    wait_d = '0;
    if (in_mem_state && !rdy && !timeout) begin
      wait_d = wait_q + 8'd1;
    end
  end

  assign op_d = (state_q == StDecode) ? opcode : op_q;

  always_comb begin
    state_d                = state_q;
    alusrcA                = 1'b0;
    alusrcB                = 2'b00;
    ext_zero               = 1'b0;
    aluop                  = 3'b000;
    memread                = 1'b0;
    memwrite               = 1'b0;
    IorD                   = 1'b0;
    IR_write               = 1'b0;
    regwrite               = 1'b0;
    regdst                 = 2'b00;
    memtoreg               = 2'b00;
    pcsrc                  = 2'b00;
    pc_write               = 1'b0;
    pc_write_condition_beq = 1'b0;
    pc_write_condition_bne = 1'b0;
    instr_done             = 1'b0;
    illegal_op             = 1'b0;
    mem_timeout            = 1'b0;
    if (!reset) begin
      case (state_q)
        StFetch: begin
          memread = 1'b1;
          alusrcB = 2'b01;
          if (rdy) begin
            IR_write = 1'b1;
            pc_write = 1'b1;
            state_d  = StDecode;
          end else if (timeout) begin
            mem_timeout = 1'b1;
            state_d     = StFetch;
          end
        end
        StDecode: begin
          alusrcB = 2'b11;
          case (opcode)
            OpRtype:                       state_d = StExecR;
            OpAddi, OpSlti, OpAndi, OpOri: state_d = StExecI;
            OpLw, OpSw:                    state_d = StMemAddr;
            OpBeq, OpBne:                  state_d = StBranch;
            OpJ:                           state_d = StJump;
            OpJal:                         state_d = StJal;
            OpJr:                          state_d = StJr;
            default: begin
              illegal_op = 1'b1;
              instr_done = 1'b1;
              state_d    = StFetch;
            end
          endcase
        end
        StExecR: begin
          alusrcA = 1'b1;
          aluop   = 3'b010;
          state_d = StAluWb;
        end
        StExecI: begin
          alusrcA = 1'b1;
          alusrcB = 2'b10;
          case (op_q)
            OpSlti: aluop = 3'b101;
            OpAndi: begin
              aluop    = 3'b011;
              ext_zero = 1'b1;
            end
            OpOri: begin
              aluop    = 3'b100;
              ext_zero = 1'b1;
            end
            default: aluop = 3'b000;
          endcase
          state_d = StAluWb;
        end
        StAluWb: begin
          regwrite   = 1'b1;
          regdst     = (op_q == OpRtype) ? 2'b01 : 2'b00;
          instr_done = 1'b1;
          state_d    = StFetch;
        end
        StMemAddr: begin
          alusrcA = 1'b1;
          alusrcB = 2'b10;
          state_d = (op_q == OpLw) ? StMemRd : StMemWr;
        end
        StMemRd: begin
          memread = 1'b1;
          IorD    = 1'b1;
          if (rdy) begin
            state_d = StMemWb;
          end else if (timeout) begin
            mem_timeout = 1'b1;
            state_d     = StFetch;
          end
        end
        StMemWb: begin
          regwrite   = 1'b1;
          memtoreg   = 2'b01;
          instr_done = 1'b1;
          state_d    = StFetch;
        end
        StMemWr: begin
          memwrite = 1'b1;
          IorD     = 1'b1;
          if (rdy) begin
            instr_done = 1'b1;
            state_d    = StFetch;
          end else if (timeout) begin
            mem_timeout = 1'b1;
            state_d     = StFetch;
          end
        end
        StBranch: begin
          alusrcA                = 1'b1;
          aluop                  = 3'b001;
          pcsrc                  = 2'b01;
          pc_write_condition_beq = (op_q == OpBeq);
          pc_write_condition_bne = (op_q == OpBne);
          instr_done             = 1'b1;
          state_d                = StFetch;
        end
        StJump: begin
          pc_write   = 1'b1;
          pcsrc      = 2'b01;
          instr_done = 1'b1;
          state_d    = StFetch;
        end
        StJal: begin
          pc_write   = 1'b1;
          pcsrc      = 2'b01;
          regwrite   = 1'b1;
          regdst     = 2'b10;
          memtoreg   = 2'b10;
          instr_done = 1'b1;
          state_d    = StFetch;
        end
        StJr: begin
          pc_write   = 1'b1;
          pcsrc      = 2'b10;
          instr_done = 1'b1;
          state_d    = StFetch;
        end
        default: state_d = StFetch;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StFetch;
      op_q    <= '0;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      wait_q  <= wait_d;
    end
  end

endmodule
